// File: rtl/flit_arbiter.sv
// -----------------------------------------------------------------------------
// flit_arbiter
//
// Round-robin N:1 merge stage placed after a set of flit queues. Each cycle it
// picks one valid head flit and registers it into a single-entry output stage
// that feeds the router output or link. The rotating priority pointer moves
// only when a flit is accepted, so fairness is counted per flit.
//
// Ports:
//   clk             system clock
//   rst_n           synchronous active-low reset
//   in_flit         head flit of each upstream queue (NUM_PORTS entries)
//   in_flit_valid   per-port valid
//   in_flit_ready   per-port ready, at most one bit high
//   out_flit_ready  downstream ready
//   out_flit_valid  output register holds a flit
//   out_flit        registered flit
//   out_port_id     index of the input that supplied out_flit
// -----------------------------------------------------------------------------

package types;
  typedef struct packed {
    logic        head;
    logic        tail;
    logic [3:0]  vc;
    logic [25:0] payload;
  } flit_t;
endpackage

module flit_arbiter #(
  parameter int NUM_PORTS     = 4,
  parameter int PORT_ID_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic [NUM_PORTS-1:0][$bits(types::flit_t)-1:0] in_flit,
  input  logic [NUM_PORTS-1:0]                           in_flit_valid,
  output logic [NUM_PORTS-1:0]                           in_flit_ready,
  input  logic                                           out_flit_ready,
  output logic                                           out_flit_valid,
  output logic [$bits(types::flit_t)-1:0]                out_flit,
  output logic [PORT_ID_WIDTH-1:0]                       out_port_id
);

  localparam int FLIT_W = $bits(types::flit_t);
  // One extra bit so last_grant + offset (at most 2*NUM_PORTS-1) never overflows.
  localparam int SUM_W  = PORT_ID_WIDTH + 1;

  localparam logic [NUM_PORTS-1:0]     PORT0_ONEHOT = NUM_PORTS'(1'b1);
  localparam logic [SUM_W-1:0]         NUM_PORTS_W  = SUM_W'(NUM_PORTS);
  localparam logic [PORT_ID_WIDTH-1:0] LAST_PORT    = PORT_ID_WIDTH'(NUM_PORTS - 1);

  logic                     out_valid_q, out_valid_d;
  logic [FLIT_W-1:0]        out_flit_q, out_flit_d;
  logic [PORT_ID_WIDTH-1:0] out_port_q, out_port_d;
  logic [PORT_ID_WIDTH-1:0] last_grant_q, last_grant_d;

  logic                     can_load_s;
  logic                     grant_found_s;
  logic [PORT_ID_WIDTH-1:0] grant_idx_s;
  logic                     load_s;

  // Output stage can take a new flit when it is empty or is draining this cycle.
  always_comb begin
    can_load_s = !out_valid_q || out_flit_ready;
  end

  // Rotating search starting just after last_grant; the wrap is a conditional
  // subtract so it stays correct for non-power-of-two port counts.
  always_comb begin : grant_search
    logic [SUM_W-1:0] cand;
    cand          = '0;
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    for (int off = 1; off <= NUM_PORTS; off++) begin
      cand = {1'b0, last_grant_q} + SUM_W'(off);
      if (cand >= NUM_PORTS_W) begin
        cand = cand - NUM_PORTS_W;
      end else begin
        cand = cand;
      end
      if (!grant_found_s && in_flit_valid[cand[PORT_ID_WIDTH-1:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand[PORT_ID_WIDTH-1:0];
      end else begin
        grant_found_s = grant_found_s;
        grant_idx_s   = grant_idx_s;
      end
    end
  end

  // Handshake: ready only for the granted port, and never while in reset.
  always_comb begin
    load_s = rst_n && can_load_s && grant_found_s;
    if (load_s) begin
      in_flit_ready = PORT0_ONEHOT << grant_idx_s;
    end else begin
      in_flit_ready = '0;
    end
  end

  // Next-state for the output register and priority pointer; a pop and a load
  // in the same cycle simply overwrite the register (no bubble).
  always_comb begin
    out_valid_d  = out_valid_q;
    out_flit_d   = out_flit_q;
    out_port_d   = out_port_q;
    last_grant_d = last_grant_q;
    if (load_s) begin
      out_valid_d  = 1'b1;
      out_flit_d   = in_flit[grant_idx_s];
      out_port_d   = grant_idx_s;
      last_grant_d = grant_idx_s;
    end else if (out_flit_ready) begin
      out_valid_d  = 1'b0;
    end else begin
      out_valid_d  = out_valid_q;
    end
  end

  // State registers with synchronous reset; pointer resets so port 0 is next.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_flit_q   <= '0;
      out_port_q   <= '0;
      last_grant_q <= LAST_PORT;
    end else begin
      out_valid_q  <= out_valid_d;
      out_flit_q   <= out_flit_d;
      out_port_q   <= out_port_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_flit_valid = out_valid_q;
  assign out_flit       = out_flit_q;
  assign out_port_id    = out_port_q;

endmodule

// File: tb/tb_flit_arbiter.sv
// -----------------------------------------------------------------------------
// tb_flit_arbiter
//
// Drives three arbiters (4, 3 and 1 ports) from shared stimulus. A table of
// hand-derived vectors and a few hand sequences cover the directed cases; a
// randomized phase is checked each cycle against a behavioural model
// (modulo-arithmetic round-robin) plus a per-port sequence scoreboard.
// -----------------------------------------------------------------------------
module tb_flit_arbiter;

  localparam int FW = $bits(types::flit_t);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              out_ready;
  logic [3:0]        in_valid;
  logic [3:0][FW-1:0] in_flit;

  logic [3:0]        rdy4;
  logic [2:0]        rdy3;
  logic [0:0]        rdy1;
  logic              ov4, ov3, ov1;
  logic [FW-1:0]     of4, of3, of1;
  logic [1:0]        op4, op3;
  logic [0:0]        op1;

  always #5 clk = ~clk;

  flit_arbiter #(.NUM_PORTS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_flit(in_flit), .in_flit_valid(in_valid),
    .in_flit_ready(rdy4), .out_flit_ready(out_ready), .out_flit_valid(ov4),
    .out_flit(of4), .out_port_id(op4));

  flit_arbiter #(.NUM_PORTS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_flit(in_flit[2:0]), .in_flit_valid(in_valid[2:0]),
    .in_flit_ready(rdy3), .out_flit_ready(out_ready), .out_flit_valid(ov3),
    .out_flit(of3), .out_port_id(op3));

  flit_arbiter #(.NUM_PORTS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_flit(in_flit[0:0]), .in_flit_valid(in_valid[0:0]),
    .in_flit_ready(rdy1), .out_flit_ready(out_ready), .out_flit_valid(ov1),
    .out_flit(of1), .out_port_id(op1));

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state for the three instances.
  int            nports[3] = '{4, 3, 1};
  logic          m_v[3], n_v[3];
  logic [FW-1:0] m_f[3], n_f[3];
  int            m_p[3], n_p[3];
  int            m_ptr[3], n_ptr[3];
  logic          stall_pend[3];
  logic [FW-1:0] hold_f[3];
  int            hold_p[3];

  // Scoreboard for the 4-port instance.
  logic sb_on = 1'b0;
  int   src_seq[4];
  int   exp_seq[4];
  int   n_accepted, n_consumed, n_discarded;

  typedef struct {
    logic       rst_n;
    logic [3:0] valid;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_v;
    int         exp_port;
  } vec_t;
  vec_t tbl[20];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] fixed_flit(input int p);
    return 32'hC0DE_0000 | 32'(p);
  endfunction

  function automatic int m_grant(input int k);
    int c;
    for (int off = 1; off <= nports[k]; off++) begin
      c = (m_ptr[k] + off) % nports[k];
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_ready(input int k);
    int g;
    if (!rst_n) return 4'b0000;
    g = m_grant(k);
    if ((!m_v[k] || out_ready) && g >= 0) return 4'(1) << g;
    return 4'b0000;
  endfunction

  function automatic logic [3:0] act_rdy(input int k);
    case (k)
      0:       return rdy4;
      1:       return {1'b0, rdy3};
      default: return {3'b000, rdy1};
    endcase
  endfunction

  function automatic logic act_v(input int k);
    case (k)
      0:       return ov4;
      1:       return ov3;
      default: return ov1;
    endcase
  endfunction

  function automatic logic [FW-1:0] act_f(input int k);
    case (k)
      0:       return of4;
      1:       return of3;
      default: return of1;
    endcase
  endfunction

  function automatic int act_port(input int k);
    case (k)
      0:       return int'(op4);
      1:       return int'(op3);
      default: return int'(op1);
    endcase
  endfunction

  task automatic model_init();
    for (int k = 0; k < 3; k++) begin
      m_v[k] = 1'b0; m_f[k] = '0; m_p[k] = 0; m_ptr[k] = nports[k] - 1;
      stall_pend[k] = 1'b0;
    end
  endtask

  // One clock: check at the falling edge, step model across the rising edge.
  task automatic cycle();
    logic [3:0] r;
    int g;
    int p;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      r = m_ready(k);
      chk($sformatf("ready n=%0d", nports[k]), 64'(act_rdy(k)), 64'(r));
      chk($sformatf("onehot0 n=%0d", nports[k]), 64'($onehot0(act_rdy(k))), 64'(1));
      chk($sformatf("out_valid n=%0d", nports[k]), 64'(act_v(k)), 64'(m_v[k]));
      chk($sformatf("out_flit n=%0d", nports[k]), 64'(act_f(k)), 64'(m_f[k]));
      chk($sformatf("out_port_id n=%0d", nports[k]), 64'(act_port(k)), 64'(m_p[k]));
      if (stall_pend[k]) begin
        chk($sformatf("stall_valid n=%0d", nports[k]), 64'(act_v(k)), 64'(1));
        chk($sformatf("stall_flit n=%0d", nports[k]), 64'(act_f(k)), 64'(hold_f[k]));
        chk($sformatf("stall_port n=%0d", nports[k]), 64'(act_port(k)), 64'(hold_p[k]));
      end
      hold_f[k]     = act_f(k);
      hold_p[k]     = act_port(k);
      stall_pend[k] = act_v(k) && !out_ready && rst_n;
      if (!rst_n) begin
        n_v[k] = 1'b0; n_f[k] = '0; n_p[k] = 0; n_ptr[k] = nports[k] - 1;
      end else if (r != 4'b0000) begin
        g = m_grant(k);
        n_v[k] = 1'b1; n_f[k] = in_flit[g]; n_p[k] = g; n_ptr[k] = g;
      end else begin
        n_v[k] = m_v[k] && !out_ready; n_f[k] = m_f[k]; n_p[k] = m_p[k]; n_ptr[k] = m_ptr[k];
      end
    end
    if (sb_on) begin
      for (int q = 0; q < 4; q++) begin
        if (rst_n && rdy4[q] && in_valid[q]) begin
          src_seq[q]++;
          n_accepted++;
        end
      end
      p = int'(op4);
      if (ov4 && out_ready && rst_n) begin
        chk("sb_port_tag", 64'(of4[31:16]), 64'(p));
        chk("sb_seq", 64'(of4[15:0]), 64'(exp_seq[p] & 16'hFFFF));
        exp_seq[p]++;
        n_consumed++;
      end else if (!rst_n && ov4) begin
        exp_seq[p]++;
        n_discarded++;
      end
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      m_v[k] = n_v[k]; m_f[k] = n_f[k]; m_p[k] = n_p[k]; m_ptr[k] = n_ptr[k];
    end
    #1;
  endtask

  initial begin
    // Directed vectors for the 4-port instance (ready during cycle, state after edge).
    tbl[0]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 0};
    tbl[1]  = '{1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1, 2};
    tbl[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 0};
    tbl[3]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 0};
    tbl[4]  = '{1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 1};
    tbl[5]  = '{1'b1, 4'b1111, 1'b1, 4'b0100, 1'b1, 2};
    tbl[6]  = '{1'b1, 4'b1111, 1'b1, 4'b1000, 1'b1, 3};
    tbl[7]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 0};
    tbl[8]  = '{1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 1};
    tbl[9]  = '{1'b1, 4'b1111, 1'b1, 4'b0100, 1'b1, 2};
    tbl[10] = '{1'b1, 4'b1111, 1'b1, 4'b1000, 1'b1, 3};
    tbl[11] = '{1'b1, 4'b1010, 1'b0, 4'b0000, 1'b1, 3};
    tbl[12] = '{1'b1, 4'b1010, 1'b1, 4'b0010, 1'b1, 1};
    tbl[13] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 1};
    tbl[14] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 1};
    tbl[15] = '{1'b1, 4'b1000, 1'b0, 4'b1000, 1'b1, 3};
    tbl[16] = '{1'b1, 4'b0101, 1'b1, 4'b0001, 1'b1, 0};
    tbl[17] = '{1'b1, 4'b0101, 1'b1, 4'b0100, 1'b1, 2};
    tbl[18] = '{1'b1, 4'b0101, 1'b1, 4'b0001, 1'b1, 0};
    tbl[19] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 0};

    rst_n     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 4'b0000;
    for (int p = 0; p < 4; p++) in_flit[p] = fixed_flit(p);
    repeat (2) @(posedge clk);
    #1;
    model_init();

    // Table-driven directed vectors.
    for (int i = 0; i < 20; i++) begin
      rst_n     = tbl[i].rst_n;
      in_valid  = tbl[i].valid;
      out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("tbl%0d ready", i), 64'(rdy4), 64'(tbl[i].exp_rdy));
      cycle();
      chk($sformatf("tbl%0d out_valid", i), 64'(ov4), 64'(tbl[i].exp_v));
      chk($sformatf("tbl%0d out_port_id", i), 64'(op4), 64'(tbl[i].exp_port));
      if (tbl[i].exp_v) chk($sformatf("tbl%0d out_flit", i), 64'(of4), 64'(fixed_flit(tbl[i].exp_port)));
    end

    // Stall: ports 1 and 3 valid, downstream blocked for 5 cycles after first load.
    rst_n = 1'b0; in_valid = 4'b1010; out_ready = 1'b1;
    cycle();
    rst_n = 1'b1;
    cycle();
    chk("stall first port", 64'(op4), 64'(1));
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall ready", 64'(rdy4), 64'(0));
      cycle();
      chk("stall held flit", 64'(of4), 64'(fixed_flit(1)));
      chk("stall held valid", 64'(ov4), 64'(1));
    end
    out_ready = 1'b1;
    #1;
    chk("stall release ready", 64'(rdy4), 64'(4'b1000));
    cycle();
    chk("stall release port", 64'(op4), 64'(3));

    // Wrap on 3 ports and degenerate 1-port stage.
    rst_n = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk($sformatf("wrap3 grant %0d", i), 64'(op3), 64'(i % 3));
      chk($sformatf("n1 valid %0d", i), 64'(ov1), 64'(1));
      chk($sformatf("n1 port %0d", i), 64'(op1), 64'(0));
    end

    // Randomized phase with scoreboard.
    rst_n = 1'b0; in_valid = 4'b0000;
    cycle();
    for (int p = 0; p < 4; p++) begin
      src_seq[p] = 0;
      exp_seq[p] = 0;
    end
    n_accepted = 0; n_consumed = 0; n_discarded = 0;
    sb_on = 1'b1;
    for (int c = 0; c < 800; c++) begin
      rst_n     = ($urandom_range(0, 149) != 0);
      in_valid  = (c < 100) ? 4'b1111 : 4'($urandom);
      out_ready = (c < 100) ? ((c % 2) == 0) : ($urandom_range(0, 3) != 0);
      for (int p = 0; p < 4; p++) in_flit[p] = {16'(p), 16'(src_seq[p])};
      cycle();
    end
    sb_on = 1'b0;
    chk("sb_conservation", 64'(n_accepted),
        64'(n_consumed + n_discarded + (ov4 ? 1 : 0)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/flit_arbiter.md
Name: flit_arbiter

Overview:
- Round-robin N:1 merge stage that sits directly downstream of several flit_queue instances. One instance per router output.
- Picks one valid head flit per cycle and registers it into a single-entry output stage that feeds the router output or link.
- Fairness is per flit: the rotating priority pointer advances only on an accepted transfer.

Parameters:
- NUM_PORTS, 4, number of input flit streams; legal range 1..16.
- PORT_ID_WIDTH, $clog2(NUM_PORTS) but at least 1, width of the source-port tag.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; synchronous, active-low
- in_flit  input  NUM_PORTS x $bits(types::flit_t)  head flit of each upstream queue
- in_flit_valid  input  NUM_PORTS  per-port valid
- in_flit_ready  output  NUM_PORTS  per-port ready; at most one bit high per cycle
- out_flit_ready  input  1  downstream ready
- out_flit_valid  output  1  output register holds a flit
- out_flit  output  $bits(types::flit_t)  registered flit
- out_port_id  output  PORT_ID_WIDTH  index of the input that supplied out_flit

Behaviour:
- Reset is synchronous on clk when rst_n=0. On reset:
  - out_flit_valid=0, out_flit=0, out_port_id=0.
  - Priority pointer last_grant=NUM_PORTS-1, so port 0 has top priority after reset.
  - in_flit_ready=0 while rst_n=0.
- can_load = !out_flit_valid || out_flit_ready. can_load is combinational from the register state and out_flit_ready.
- Grant selection is combinational:
  - Search order is last_grant+1, last_grant+2, ... modulo NUM_PORTS.
  - The first port with in_flit_valid=1 wins.
  - With no valid port there is no grant.
- in_flit_ready[i] = can_load && grant==i. It may depend on in_flit_valid. in_flit_valid must never depend on ready.
- Transfer at a rising edge when in_flit_valid[i] && in_flit_ready[i]:
  - out_flit <= in_flit[i], out_port_id <= i, out_flit_valid <= 1, last_grant <= i.
- Output pop with no load (out_flit_valid && out_flit_ready, no input transfer):
  - out_flit_valid <= 0.
  - out_flit and out_port_id hold their old values; they are don't-care while invalid.
- Simultaneous pop and load in one cycle: the new flit replaces the old one with no bubble. Throughput is 1 flit/cycle while out_flit_ready=1.
- Stall (out_flit_valid=1, out_flit_ready=0):
  - out_flit and out_port_id stay stable.
  - All in_flit_ready=0.
  - last_grant unchanged.
- Latency: a flit accepted at edge k is visible on out_flit from edge k and is consumable in the cycle after k.
- Fairness: with all ports continuously valid, the grant order is 0,1,...,N-1,0,... and no port waits more than NUM_PORTS-1 transfers.
- Wrap-around: when last_grant=NUM_PORTS-1 the search starts at 0. The modulo must be correct for non-power-of-two NUM_PORTS, e.g. 3.
- NUM_PORTS=1:
  - Grant is always port 0 and out_port_id is always 0.
  - The block degenerates to a registered pipeline stage.
- A port whose valid drops while not granted loses nothing. The arbiter never latches a request.
- Reset mid-operation: a flit held in the output register is discarded (out_flit_valid=0 on the next cycle) and the pointer returns to NUM_PORTS-1.
- Assertions the bench must check:
  - $onehot0(in_flit_ready).
  - While stalled, out_flit and out_port_id are stable and out_flit_valid stays high.

Test Plan:
- Reset, then only port 2 valid with flit A, out_flit_ready=1 -> in_flit_ready=4'b0100. Next cycle out_flit_valid=1, out_flit=A, out_port_id=2.
- All 4 ports valid continuously, out_flit_ready=1, 8 cycles -> out_port_id sequence 0,1,2,3,0,1,2,3 with out_flit_valid=1 every cycle after the first.
- Ports 1 and 3 valid, out_flit_ready=0 for 5 cycles after the first load -> out_flit held equal to port 1's flit and all in_flit_ready=0. After ready returns, the next output is port 3.
- Back-to-back traffic with out_flit_ready toggling 1,0,1,0 -> no flit is dropped or duplicated, and the scoreboard per port matches the input order.
- NUM_PORTS=3, all valid -> order 0,1,2,0 confirms wrap.
- rst_n=0 for one cycle while out_flit_valid=1 and ports valid -> out_flit_valid=0 next cycle. The first grant after reset is the lowest valid port.
